countdown_timer_ctrl: RTL and testbench
=======================================

# countdown_timer_ctrl

Countdown timer controller that owns the one-second timebase for the display path. It divides `clock_in` internally into a single-cycle enable tick, so the design uses one clock and no derived clocks. It sequences a loadable seconds counter through idle, run, pause and expiry states. Its outputs drive the seven-segment formatter and the alarm LED.

## Interface
- `TICK_DIV`, 50000000: `clock_in` cycles per tick (1 s at 50 MHz); must be ≥ 2.
- `MAX_SEC`, 5999: saturation limit for loaded values (99:59).
- `W`, 13: width of the seconds count; must hold `MAX_SEC`.

Ports:
- `clock_in` input 1: single clock; all state changes on rising edge.
- `clear` input 1: reset, synchronous, active-high.
- `load` input 1: load `load_value` (honoured in IDLE/DONE only).
- `load_value` input W: seconds to load.
- `start` input 1: start/resume request, level-sampled per cycle.
- `pause` input 1: pause request, level-sampled per cycle.
- `remaining` output W: registered seconds remaining.
- `tick` output 1: registered one-cycle pulse per decrement.
- `running` output 1: high in RUN.
- `done` output 1: one-cycle pulse on expiry.
- `alarm` output 1: high while in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Priority each cycle: `clear` > `load` > `start`/`pause`.
- `clear`: state IDLE, `remaining`=0, prescaler=0, all outputs 0.
- `load` in IDLE or DONE:
  - `remaining` = min(`load_value`, `MAX_SEC`).
  - State becomes IDLE; `alarm` drops.
  - Ignored in RUN and PAUSED.
- IDLE:
  - `start` with `remaining`≠0 → RUN; prescaler zeroed.
  - `start` with `remaining`=0 is ignored.
  - `pause` is ignored.
- RUN:
  - Prescaler counts 0..`TICK_DIV`-1; wrap asserts `tick` next cycle and decrements `remaining`.
  - `pause` → PAUSED; `start` is ignored.
  - If `pause` coincides with the wrap, the tick and decrement still occur, then the state is PAUSED.
- PAUSED:
  - Prescaler frozen; the partial count is kept.
  - `start` → RUN, and counting resumes from the held value.
- Expiry: a decrement from 1 to 0 → DONE, `done` pulses with that `tick`, `alarm`=1.
- DONE:
  - Holds until `load` or `clear`.
  - `start` and `pause` are ignored.
- `remaining` never wraps below 0 and never exceeds `MAX_SEC`.

## Timing
- All outputs are registered.
- Reset values: `remaining`=0, `tick`=0, `running`=0, `done`=0, `alarm`=0.
- `start` sampled at edge N → `running`=1 after edge N.
- First `tick` occurs exactly `TICK_DIV` cycles after entering RUN from IDLE.
- Ticks are `TICK_DIV` cycles apart in uninterrupted RUN.
- A pause of P cycles delays the next tick by exactly P cycles.
- `load` latency: `remaining` is updated after 1 edge.
- `clear` mid-run takes effect at the next edge, with no pending tick afterward.

## Structure
- Shared package `timer_pkg`:
  - State enum (IDLE=0, RUN=1, PAUSED=2, DONE=3).
  - Default `TICK_DIV` and `MAX_SEC` constants.
- Sub-module `tick_prescaler`:
  - Inputs: `clock_in`, `clear`, `en`, `restart`.
  - Output: `tick`.
  - 32-bit counter, parameterised by `TICK_DIV`.
  - Replaces the free-running toggle divider for this path.
- Top level holds the FSM, the seconds register and the output registers.

## Test plan
All scenarios use `TICK_DIV`=4 and `MAX_SEC`=5999.
- Reset: `clear` for 2 cycles → all outputs 0, state IDLE; `start` with `remaining`=0 → `running` stays 0.
- Run to expiry: load 3, `start` → ticks on cycles 4, 8, 12; `remaining` goes 2, 1, 0; `done` pulses once on cycle 12; `alarm`=1 and held.
- Pause mid-period: load 5, `start`, `pause` at prescaler=2 for 10 cycles, then `start` → next tick 2 cycles after resume; `remaining` is 4.
- Saturation and ignored load: load 9000 → `remaining`=5999; `load` 7 while RUN → ignored, countdown continues.
- Simultaneous events, using load 2:
  - `pause` on the wrap cycle → tick happens, `remaining`=1, state PAUSED.
  - `load` + `start` together in IDLE → load wins, stays IDLE.
- Clear mid-run: `clear` during RUN at `remaining`=4 → next cycle all zero; no `tick` for 8 subsequent cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer path: FSM encoding and default sizing.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_e;

    // 1 s timebase at 50 MHz.
    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;
    // 99:59 expressed in seconds.
    localparam int unsigned MAX_SEC_DEFAULT  = 5999;
    localparam int unsigned SEC_W_DEFAULT    = 13;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock_in into a single-cycle enable. Counts 0..TICK_DIV-1 while en is
// high, holds its partial count while en is low, and reports the wrap cycle.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock_in,
    input  logic clear,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam logic [31:0] LAST_CNT = 32'(TICK_DIV - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Combinational wrap flag; the caller registers it, so it lands one edge later.
    assign tick = en && (cnt_q == LAST_CNT);

    // Next count: restart wins, otherwise advance or wrap only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 32'd1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clock_in) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: FSM, seconds register and registered outputs.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | loaded or cleared, waiting for start (needs remaining != 0)
//   ST_RUN    | prescaler counting, remaining decrements on each wrap
//   ST_PAUSED | prescaler frozen with its partial count, waiting for start
//   ST_DONE   | expired, alarm held until load or clear
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned MAX_SEC  = MAX_SEC_DEFAULT,
    parameter int unsigned W        = SEC_W_DEFAULT
) (
    input  logic         clock_in,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] remaining,
    output logic         tick,
    output logic         running,
    output logic         done,
    output logic         alarm
);

    localparam logic [W-1:0] MAX_SEC_W = W'(MAX_SEC);

    timer_state_e state_q, state_d;
    logic [W-1:0] rem_q, rem_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic         running_q, alarm_q;
    logic         pre_restart;
    logic         pre_tick;
    logic         load_ok;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock_in (clock_in),
        .clear    (clear),
        .en       (state_q == ST_RUN),
        .restart  (pre_restart),
        .tick     (pre_tick)
    );

    assign load_ok = load && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state logic: load beats start/pause; a wrap on the final second wins over pause.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        pre_restart = 1'b0;
        if (load_ok) begin
            rem_d   = (load_value > MAX_SEC_W) ? MAX_SEC_W : load_value;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (rem_q != '0)) begin
                        state_d     = ST_RUN;
                        pre_restart = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pre_tick) begin
                        tick_d = 1'b1;
                        if (rem_q != '0) begin
                            rem_d = rem_q - W'(1);
                        end
                    end
                    if (pre_tick && (rem_q <= W'(1))) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; clear dominates everything.
    always_ff @(posedge clock_in) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_DONE);
        end
    end

    assign remaining = rem_q;
    assign tick      = tick_q;
    assign done      = done_q;
    assign running   = running_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with a 4-cycle timebase.
module tb_countdown_timer_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_SEC  = 5999;
    localparam int unsigned W        = 14;

    logic         clk = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] remaining;
    logic         tick;
    logic         running;
    logic         done;
    logic         alarm;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;

    countdown_timer_ctrl #(
        .TICK_DIV (TICK_DIV),
        .MAX_SEC  (MAX_SEC),
        .W        (W)
    ) dut (
        .clock_in   (clk),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .remaining  (remaining),
        .tick       (tick),
        .running    (running),
        .done       (done),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (done === 1'b1) n_done++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rem"}, 32'(remaining), 0);
        chk({tag, ".tick"}, 32'(tick), 0);
        chk({tag, ".run"}, 32'(running), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".alarm"}, 32'(alarm), 0);
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_value = W'(v);
        step();
        load = 1'b0;
    endtask

    initial begin
        // Reset
        #2;
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        chk_all_zero("reset");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_zero.run", 32'(running), 0);

        // Run to expiry: load 3
        do_load(3);
        chk("ld3.rem", 32'(remaining), 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run0.run", 32'(running), 1);
        chk("run0.tick", 32'(tick), 0);
        n_done = 0;
        for (int c = 1; c <= 13; c++) begin
            step();
            chk($sformatf("exp%0d.tick", c), 32'(tick), ((c % 4 == 0) && (c <= 12)) ? 1 : 0);
            chk($sformatf("exp%0d.rem", c), 32'(remaining), (c >= 12) ? 0 : 3 - c / 4);
            chk($sformatf("exp%0d.done", c), 32'(done), (c == 12) ? 1 : 0);
            chk($sformatf("exp%0d.alarm", c), 32'(alarm), (c >= 12) ? 1 : 0);
            chk($sformatf("exp%0d.run", c), 32'(running), (c < 12) ? 1 : 0);
        end
        start = 1'b1;
        pause = 1'b1;
        step();
        step();
        start = 1'b0;
        pause = 1'b0;
        chk("done_hold.run", 32'(running), 0);
        chk("done_hold.alarm", 32'(alarm), 1);
        chk("done_count", 32'(n_done), 1);

        // Pause mid-period: load 5 from DONE
        do_load(5);
        chk("ld5.rem", 32'(remaining), 5);
        chk("ld5.alarm", 32'(alarm), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("paused.run", 32'(running), 0);
        for (int c = 3; c <= 11; c++) begin
            step();
            chk($sformatf("hold%0d.tick", c), 32'(tick), 0);
            chk($sformatf("hold%0d.rem", c), 32'(remaining), 5);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume.run", 32'(running), 1);
        step();
        chk("resume1.tick", 32'(tick), 0);
        step();
        chk("resume2.tick", 32'(tick), 1);
        chk("resume2.rem", 32'(remaining), 4);

        // Clear mid-run at remaining=4
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_all_zero("clr");
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("clr%0d.tick", c), 32'(tick), 0);
            chk($sformatf("clr%0d.run", c), 32'(running), 0);
        end

        // Saturation and ignored loads
        do_load(9000);
        chk("sat9000", 32'(remaining), 5999);
        do_load(5998);
        chk("ld5998", 32'(remaining), 5998);
        do_load(6000);
        chk("sat6000", 32'(remaining), 5999);
        start = 1'b1;
        step();
        start = 1'b0;
        do_load(7);
        chk("ldrun.rem", 32'(remaining), 5999);
        chk("ldrun.run", 32'(running), 1);
        step();
        step();
        step();
        chk("ldrun4.tick", 32'(tick), 1);
        chk("ldrun4.rem", 32'(remaining), 5998);
        pause = 1'b1;
        step();
        pause = 1'b0;
        do_load(7);
        chk("ldpause.rem", 32'(remaining), 5998);
        chk("ldpause.run", 32'(running), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Simultaneous events with load 2
        load = 1'b1;
        start = 1'b1;
        load_value = W'(2);
        step();
        load = 1'b0;
        start = 1'b0;
        chk("ldstart.rem", 32'(remaining), 2);
        chk("ldstart.run", 32'(running), 0);
        step();
        chk("ldstart1.run", 32'(running), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("prewrap.tick", 32'(tick), 0);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("pwrap.tick", 32'(tick), 1);
        chk("pwrap.rem", 32'(remaining), 1);
        chk("pwrap.run", 32'(running), 0);
        chk("pwrap.done", 32'(done), 0);
        step();
        chk("pwrap1.tick", 32'(tick), 0);
        chk("pwrap1.rem", 32'(remaining), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("res2.run", 32'(running), 1);
        step();
        step();
        step();
        chk("res2_3.tick", 32'(tick), 0);
        step();
        chk("res2_4.tick", 32'(tick), 1);
        chk("res2_4.done", 32'(done), 1);
        chk("res2_4.rem", 32'(remaining), 0);
        chk("res2_4.alarm", 32'(alarm), 1);
        step();
        chk("res2_5.done", 32'(done), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
